id_stage_hazard: RTL and testbench

- Parametrised next-generation MIPS instruction decode stage: instruction decode, register file and ID/EX pipeline register in one block.
- Sits between the IF/ID register and the execute stage.
- Decodes a MIPS subset and reads the register file with write-through bypass from writeback.
- Detects load-use hazards, stalls upstream, inserts bubbles, and honours a flush from branch resolution.

---
 rtl/id_stage_hazard.sv | 316 +++++++++++++++++++++++++++++++
 tb/tb_id_stage_hazard.sv | 267 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/id_stage_hazard.sv
// Purpose : MIPS-subset instruction decode, register file with WB bypass, and ID/EX pipeline register.
// Latency : 1 cycle; an instruction presented in ID appears on EX_* after the next rising edge.
// Backpressure: ID_Stall (combinational) holds PC and IF/ID on a load-use hazard and a bubble enters EX; Flush overrides it.
//
// Ports:
//   Clock, Reset                    rising-edge clock, asynchronous active-low reset
//   IF_Valid/IF_Instruction/IF_PCPlus4  instruction from the IF/ID register
//   Flush                           kill the instruction currently in ID (bubble on next edge)
//   WB_RegWrite/WB_WriteReg/WB_WriteData  register file write port from writeback
//   ID_Stall                        load-use hazard, upstream must hold
//   EX_*                            registered decode results for the execute stage
module id_stage_hazard #(
  parameter int DATA_WIDTH = 32,
  parameter int REG_COUNT  = 32,
  parameter int REG_ADDR_W = 5,
  parameter bit BYPASS_EN  = 1'b1
) (
  input  logic                  Clock,
  input  logic                  Reset,
  input  logic                  IF_Valid,
  input  logic [31:0]           IF_Instruction,
  input  logic [31:0]           IF_PCPlus4,
  input  logic                  Flush,
  input  logic                  WB_RegWrite,
  input  logic [REG_ADDR_W-1:0] WB_WriteReg,
  input  logic [DATA_WIDTH-1:0] WB_WriteData,
  output logic                  ID_Stall,
  output logic                  EX_Valid,
  output logic                  EX_RegWrite,
  output logic                  EX_MemRead,
  output logic                  EX_MemWrite,
  output logic                  EX_MemToReg,
  output logic                  EX_ALUSrc,
  output logic                  EX_Branch,
  output logic [2:0]            EX_ALUOp,
  output logic                  EX_Illegal,
  output logic [DATA_WIDTH-1:0] EX_ReadData1,
  output logic [DATA_WIDTH-1:0] EX_ReadData2,
  output logic [DATA_WIDTH-1:0] EX_Imm,
  output logic [REG_ADDR_W-1:0] EX_Rs,
  output logic [REG_ADDR_W-1:0] EX_Rt,
  output logic [REG_ADDR_W-1:0] EX_Rd,
  output logic [31:0]           EX_PCPlus4,
  output logic [31:0]           EX_BranchTarget
);

  // Opcodes and R-type function codes of the supported subset.
  localparam logic [5:0] OP_RTYPE = 6'h00;
  localparam logic [5:0] OP_SPEC2 = 6'h1C;
  localparam logic [5:0] OP_ADDI  = 6'h08;
  localparam logic [5:0] OP_ANDI  = 6'h0C;
  localparam logic [5:0] OP_ORI   = 6'h0D;
  localparam logic [5:0] OP_LW    = 6'h23;
  localparam logic [5:0] OP_SW    = 6'h2B;
  localparam logic [5:0] OP_BEQ   = 6'h04;

  localparam logic [5:0] FN_ADD = 6'h20;
  localparam logic [5:0] FN_SUB = 6'h22;
  localparam logic [5:0] FN_AND = 6'h24;
  localparam logic [5:0] FN_OR  = 6'h25;
  localparam logic [5:0] FN_SLT = 6'h2A;
  localparam logic [5:0] FN_MUL = 6'h02;

  typedef enum logic [2:0] {
    ALU_ADD = 3'd0,
    ALU_SUB = 3'd1,
    ALU_AND = 3'd2,
    ALU_OR  = 3'd3,
    ALU_SLT = 3'd4,
    ALU_MUL = 3'd5
  } alu_op_e;

  typedef struct packed {
    logic                  valid;
    logic                  reg_write;
    logic                  mem_read;
    logic                  mem_write;
    logic                  mem_to_reg;
    logic                  alu_src;
    logic                  branch;
    logic                  illegal;
    alu_op_e               alu_op;
    logic [DATA_WIDTH-1:0] rd1;
    logic [DATA_WIDTH-1:0] rd2;
    logic [DATA_WIDTH-1:0] imm;
    logic [REG_ADDR_W-1:0] rs;
    logic [REG_ADDR_W-1:0] rt;
    logic [REG_ADDR_W-1:0] rd;
    logic [31:0]           pc_plus4;
    logic [31:0]           br_target;
  } idex_t;

  // ---------------------------------------------------------------------------
  // Instruction fields
  // ---------------------------------------------------------------------------
  logic [5:0]            op;
  logic [5:0]            funct;
  logic [REG_ADDR_W-1:0] rs_idx;
  logic [REG_ADDR_W-1:0] rt_idx;
  logic [REG_ADDR_W-1:0] rd_idx;
  logic [DATA_WIDTH-1:0] imm_sext;
  logic [DATA_WIDTH-1:0] imm_zext;
  logic [31:0]           br_target;

  assign op       = IF_Instruction[31:26];
  assign funct    = IF_Instruction[5:0];
  assign rs_idx   = REG_ADDR_W'(IF_Instruction[25:21]);
  assign rt_idx   = REG_ADDR_W'(IF_Instruction[20:16]);
  assign rd_idx   = REG_ADDR_W'(IF_Instruction[15:11]);
  assign imm_sext = {{(DATA_WIDTH-16){IF_Instruction[15]}}, IF_Instruction[15:0]};
  assign imm_zext = {{(DATA_WIDTH-16){1'b0}}, IF_Instruction[15:0]};
  // Word offset, always 32-bit wide regardless of DATA_WIDTH; wraps mod 2^32.
  assign br_target = IF_PCPlus4 + {{14{IF_Instruction[15]}}, IF_Instruction[15:0], 2'b00};

  // ---------------------------------------------------------------------------
  // Decode. Controls are only raised inside recognised encodings, so anything
  // unrecognised falls out with every control at zero and legal = 0.
  // ---------------------------------------------------------------------------
  logic    legal;
  logic    uses_rt;
  logic    dst_is_rd;
  logic    zext_imm;
  logic    c_reg_write;
  logic    c_mem_read;
  logic    c_mem_write;
  logic    c_mem_to_reg;
  logic    c_alu_src;
  logic    c_branch;
  alu_op_e c_alu_op;

  always_comb begin
    legal        = 1'b0;
    uses_rt      = 1'b0;
    dst_is_rd    = 1'b0;
    zext_imm     = 1'b0;
    c_reg_write  = 1'b0;
    c_mem_read   = 1'b0;
    c_mem_write  = 1'b0;
    c_mem_to_reg = 1'b0;
    c_alu_src    = 1'b0;
    c_branch     = 1'b0;
    c_alu_op     = ALU_ADD;

    case (op)
      OP_RTYPE: begin
        dst_is_rd = 1'b1;
        case (funct)
          FN_ADD: begin legal = 1'b1; c_alu_op = ALU_ADD; end
          FN_SUB: begin legal = 1'b1; c_alu_op = ALU_SUB; end
          FN_AND: begin legal = 1'b1; c_alu_op = ALU_AND; end
          FN_OR:  begin legal = 1'b1; c_alu_op = ALU_OR;  end
          FN_SLT: begin legal = 1'b1; c_alu_op = ALU_SLT; end
          default: ;
        endcase
        c_reg_write = legal;
        uses_rt     = legal;
      end
      OP_SPEC2: begin
        dst_is_rd = 1'b1;
        if (funct == FN_MUL) begin
          legal       = 1'b1;
          c_alu_op    = ALU_MUL;
          c_reg_write = 1'b1;
          uses_rt     = 1'b1;
        end
      end
      OP_ADDI: begin
        legal       = 1'b1;
        c_reg_write = 1'b1;
        c_alu_src   = 1'b1;
        c_alu_op    = ALU_ADD;
      end
      OP_ANDI: begin
        legal       = 1'b1;
        c_reg_write = 1'b1;
        c_alu_src   = 1'b1;
        c_alu_op    = ALU_AND;
        zext_imm    = 1'b1;
      end
      OP_ORI: begin
        legal       = 1'b1;
        c_reg_write = 1'b1;
        c_alu_src   = 1'b1;
        c_alu_op    = ALU_OR;
        zext_imm    = 1'b1;
      end
      OP_LW: begin
        legal        = 1'b1;
        c_reg_write  = 1'b1;
        c_mem_read   = 1'b1;
        c_mem_to_reg = 1'b1;
        c_alu_src    = 1'b1;
        c_alu_op     = ALU_ADD;
      end
      OP_SW: begin
        legal       = 1'b1;
        c_mem_write = 1'b1;
        c_alu_src   = 1'b1;
        c_alu_op    = ALU_ADD;
        uses_rt     = 1'b1;
      end
      OP_BEQ: begin
        legal    = 1'b1;
        c_branch = 1'b1;
        c_alu_op = ALU_SUB;
        uses_rt  = 1'b1;
      end
      default: ;
    endcase
  end

  // ---------------------------------------------------------------------------
  // Register file. r0 is never written, so it stays at its reset value of 0.
  // ---------------------------------------------------------------------------
  logic [DATA_WIDTH-1:0] rf_q [REG_COUNT];
  logic [DATA_WIDTH-1:0] rf_d [REG_COUNT];

  always_comb begin
    rf_d = rf_q;
    if (WB_RegWrite && (WB_WriteReg != '0)) begin
      rf_d[WB_WriteReg] = WB_WriteData;
    end
  end

  // Read ports. The bypass compares against a non-zero index so a WB write
  // aimed at r0 can never leak onto an r0 read.
  logic [DATA_WIDTH-1:0] rd1_val;
  logic [DATA_WIDTH-1:0] rd2_val;

  always_comb begin
    rd1_val = rf_q[rs_idx];
    rd2_val = rf_q[rt_idx];
    if (BYPASS_EN && WB_RegWrite && (WB_WriteReg != '0)) begin
      if (WB_WriteReg == rs_idx) rd1_val = WB_WriteData;
      if (WB_WriteReg == rt_idx) rd2_val = WB_WriteData;
    end
    if (rs_idx == '0) rd1_val = '0;
    if (rt_idx == '0) rd2_val = '0;
  end

  // ---------------------------------------------------------------------------
  // Load-use hazard: the load in EX has not produced its data yet, so an ID
  // instruction that reads the load destination waits one cycle. WB-vs-ID
  // conflicts need no stall because the read ports already bypass.
  // ---------------------------------------------------------------------------
  idex_t idex_q;
  idex_t idex_d;
  logic  load_use;
  logic  id_stall;

  always_comb begin
    load_use = IF_Valid && idex_q.valid && idex_q.mem_read && (idex_q.rd != '0) &&
               ((idex_q.rd == rs_idx) || (uses_rt && (idex_q.rd == rt_idx)));
    id_stall = load_use && !Flush;
  end

  assign ID_Stall = id_stall;

  // ---------------------------------------------------------------------------
  // ID/EX register input. A bubble is all zeros: no write, no memory access.
  // ---------------------------------------------------------------------------
  always_comb begin
    idex_d = '0;
    if (IF_Valid && !Flush && !id_stall) begin
      idex_d.valid      = 1'b1;
      idex_d.reg_write  = c_reg_write;
      idex_d.mem_read   = c_mem_read;
      idex_d.mem_write  = c_mem_write;
      idex_d.mem_to_reg = c_mem_to_reg;
      idex_d.alu_src    = c_alu_src;
      idex_d.branch     = c_branch;
      idex_d.alu_op     = c_alu_op;
      idex_d.illegal    = !legal;
      idex_d.rd1        = rd1_val;
      idex_d.rd2        = rd2_val;
      idex_d.imm        = zext_imm ? imm_zext : imm_sext;
      idex_d.rs         = rs_idx;
      idex_d.rt         = rt_idx;
      idex_d.rd         = dst_is_rd ? rd_idx : rt_idx;
      idex_d.pc_plus4   = IF_PCPlus4;
      idex_d.br_target  = br_target;
    end
  end

  always_ff @(posedge Clock or negedge Reset) begin
    if (!Reset) begin
      idex_q <= '0;
      rf_q   <= '{default: '0};
    end else begin
      idex_q <= idex_d;
      rf_q   <= rf_d;
    end
  end

  // ---------------------------------------------------------------------------
  // Outputs
  // ---------------------------------------------------------------------------
  assign EX_Valid        = idex_q.valid;
  assign EX_RegWrite     = idex_q.reg_write;
  assign EX_MemRead      = idex_q.mem_read;
  assign EX_MemWrite     = idex_q.mem_write;
  assign EX_MemToReg     = idex_q.mem_to_reg;
  assign EX_ALUSrc       = idex_q.alu_src;
  assign EX_Branch       = idex_q.branch;
  assign EX_ALUOp        = idex_q.alu_op;
  assign EX_Illegal      = idex_q.illegal;
  assign EX_ReadData1    = idex_q.rd1;
  assign EX_ReadData2    = idex_q.rd2;
  assign EX_Imm          = idex_q.imm;
  assign EX_Rs           = idex_q.rs;
  assign EX_Rt           = idex_q.rt;
  assign EX_Rd           = idex_q.rd;
  assign EX_PCPlus4      = idex_q.pc_plus4;
  assign EX_BranchTarget = idex_q.br_target;

endmodule

// File: tb/tb_id_stage_hazard.sv
// Bench for id_stage_hazard: directed steps, expected EX contents queued at drive time and popped after the edge.
// A second instance with BYPASS_EN=0 shares the stimulus to show the non-bypassed read.
module tb_id_stage_hazard;

  typedef struct packed {
    logic        valid;
    logic        regwrite;
    logic        memread;
    logic        memwrite;
    logic        memtoreg;
    logic        alusrc;
    logic        branch;
    logic        illegal;
    logic [2:0]  aluop;
    logic [31:0] rd1;
    logic [31:0] rd2;
    logic [31:0] imm;
    logic [4:0]  rs;
    logic [4:0]  rt;
    logic [4:0]  rd;
    logic [31:0] pc4;
    logic [31:0] bt;
  } ex_t;

  // Control groups, ordered {regwrite, memread, memwrite, memtoreg, alusrc, branch, illegal}.
  localparam logic [6:0] C_ALU  = 7'b1000000;
  localparam logic [6:0] C_ALUI = 7'b1000100;
  localparam logic [6:0] C_LW   = 7'b1101100;
  localparam logic [6:0] C_SW   = 7'b0010100;
  localparam logic [6:0] C_BEQ  = 7'b0000010;
  localparam logic [6:0] C_ILL  = 7'b0000001;
  localparam ex_t        BUB    = '0;

  logic        Clock = 1'b0;
  logic        Reset = 1'b0;
  logic        IF_Valid = 1'b0;
  logic [31:0] IF_Instruction = '0;
  logic [31:0] IF_PCPlus4 = '0;
  logic        Flush = 1'b0;
  logic        WB_RegWrite = 1'b0;
  logic [4:0]  WB_WriteReg = '0;
  logic [31:0] WB_WriteData = '0;

  logic        ID_Stall, EX_Valid, EX_RegWrite, EX_MemRead, EX_MemWrite, EX_MemToReg, EX_ALUSrc, EX_Branch, EX_Illegal;
  logic [2:0]  EX_ALUOp;
  logic [31:0] EX_ReadData1, EX_ReadData2, EX_Imm, EX_PCPlus4, EX_BranchTarget;
  logic [4:0]  EX_Rs, EX_Rt, EX_Rd;

  logic        b_stall, b_valid, b_rw, b_mr, b_mw, b_m2r, b_as, b_br, b_ill;
  logic [2:0]  b_aluop;
  logic [31:0] b_rd1, b_rd2, b_imm, b_pc4, b_bt;
  logic [4:0]  b_rs, b_rt, b_rd;

  always #5 Clock = ~Clock;

  id_stage_hazard #(.DATA_WIDTH(32), .REG_COUNT(32), .REG_ADDR_W(5), .BYPASS_EN(1'b1)) dut (
    .Clock(Clock), .Reset(Reset), .IF_Valid(IF_Valid), .IF_Instruction(IF_Instruction),
    .IF_PCPlus4(IF_PCPlus4), .Flush(Flush), .WB_RegWrite(WB_RegWrite), .WB_WriteReg(WB_WriteReg),
    .WB_WriteData(WB_WriteData), .ID_Stall(ID_Stall), .EX_Valid(EX_Valid), .EX_RegWrite(EX_RegWrite),
    .EX_MemRead(EX_MemRead), .EX_MemWrite(EX_MemWrite), .EX_MemToReg(EX_MemToReg), .EX_ALUSrc(EX_ALUSrc),
    .EX_Branch(EX_Branch), .EX_ALUOp(EX_ALUOp), .EX_Illegal(EX_Illegal), .EX_ReadData1(EX_ReadData1),
    .EX_ReadData2(EX_ReadData2), .EX_Imm(EX_Imm), .EX_Rs(EX_Rs), .EX_Rt(EX_Rt), .EX_Rd(EX_Rd),
    .EX_PCPlus4(EX_PCPlus4), .EX_BranchTarget(EX_BranchTarget)
  );

  id_stage_hazard #(.DATA_WIDTH(32), .REG_COUNT(32), .REG_ADDR_W(5), .BYPASS_EN(1'b0)) dut_nobyp (
    .Clock(Clock), .Reset(Reset), .IF_Valid(IF_Valid), .IF_Instruction(IF_Instruction),
    .IF_PCPlus4(IF_PCPlus4), .Flush(Flush), .WB_RegWrite(WB_RegWrite), .WB_WriteReg(WB_WriteReg),
    .WB_WriteData(WB_WriteData), .ID_Stall(b_stall), .EX_Valid(b_valid), .EX_RegWrite(b_rw),
    .EX_MemRead(b_mr), .EX_MemWrite(b_mw), .EX_MemToReg(b_m2r), .EX_ALUSrc(b_as),
    .EX_Branch(b_br), .EX_ALUOp(b_aluop), .EX_Illegal(b_ill), .EX_ReadData1(b_rd1),
    .EX_ReadData2(b_rd2), .EX_Imm(b_imm), .EX_Rs(b_rs), .EX_Rt(b_rt), .EX_Rd(b_rd),
    .EX_PCPlus4(b_pc4), .EX_BranchTarget(b_bt)
  );

  ex_t obs, b_obs;
  assign obs = {EX_Valid, EX_RegWrite, EX_MemRead, EX_MemWrite, EX_MemToReg, EX_ALUSrc, EX_Branch, EX_Illegal,
                EX_ALUOp, EX_ReadData1, EX_ReadData2, EX_Imm, EX_Rs, EX_Rt, EX_Rd, EX_PCPlus4, EX_BranchTarget};
  assign b_obs = {b_valid, b_rw, b_mr, b_mw, b_m2r, b_as, b_br, b_ill,
                  b_aluop, b_rd1, b_rd2, b_imm, b_rs, b_rt, b_rd, b_pc4, b_bt};

  int          errors = 0;
  int          checks = 0;
  ex_t         sb_q[$];
  logic [31:0] pc = 32'h0040_0004;

  // Expected EX contents of a valid instruction; the branch target is pc4 + sext(imm16)*4 mod 2^32.
  function automatic ex_t mk(input logic [31:0] ins, input logic [31:0] pc4, input logic [6:0] ctl,
                             input logic [2:0] op, input logic [31:0] r1, input logic [31:0] r2,
                             input logic [31:0] imm, input logic [4:0] rd);
    ex_t e;
    e = '0;
    e.valid = 1'b1;
    {e.regwrite, e.memread, e.memwrite, e.memtoreg, e.alusrc, e.branch, e.illegal} = ctl;
    e.aluop = op;
    e.rd1   = r1;
    e.rd2   = r2;
    e.imm   = imm;
    e.rs    = ins[25:21];
    e.rt    = ins[20:16];
    e.rd    = rd;
    e.pc4   = pc4;
    e.bt    = pc4 + {{14{ins[15]}}, ins[15:0], 2'b00};
    return e;
  endfunction

  task automatic check_ex(input string tag);
    ex_t want;
    ex_t got;
    checks++;
    if (sb_q.size() == 0) begin
      errors++;
      $error("FAIL %s scoreboard empty, observed=%h", tag, obs);
    end else begin
      want = sb_q.pop_front();
      got  = obs;
      // Data fields of a bubble carry no meaning; only valid, controls and indices are checked.
      if (!want.valid) begin
        got.rd1 = '0; got.rd2 = '0; got.imm = '0; got.pc4 = '0; got.bt = '0;
      end
      assert (got === want) else begin
        errors++;
        $error("FAIL %s EX observed=%h expected=%h", tag, got, want);
      end
    end
  endtask

  // Drive one ID cycle at the falling edge, check ID_Stall, queue the EX result, then check it after the edge.
  task automatic step(input string tag, input logic vld, input logic [31:0] ins, input logic [31:0] pc4,
                      input logic fl, input logic we, input logic [4:0] wr, input logic [31:0] wd,
                      input logic exp_stall, input ex_t e);
    IF_Valid       = vld;
    IF_Instruction = ins;
    IF_PCPlus4     = pc4;
    Flush          = fl;
    WB_RegWrite    = we;
    WB_WriteReg    = wr;
    WB_WriteData   = wd;
    #1;
    checks++;
    assert (ID_Stall === exp_stall) else begin
      errors++;
      $error("FAIL %s ID_Stall observed=%b expected=%b", tag, ID_Stall, exp_stall);
    end
    sb_q.push_back(e);
    @(posedge Clock);
    @(negedge Clock);
    check_ex(tag);
  endtask

  task automatic iss(input string tag, input logic [31:0] ins, input logic exp_stall, input ex_t e);
    step(tag, 1'b1, ins, pc, 1'b0, 1'b0, 5'd0, 32'h0, exp_stall, e);
    pc = pc + 32'd4;
  endtask

  task automatic wb(input string tag, input logic [4:0] r, input logic [31:0] d);
    step(tag, 1'b0, 32'h0, pc, 1'b0, 1'b1, r, d, 1'b0, BUB);
  endtask

  task automatic chk_b_rd1(input string tag, input logic [31:0] exp_v);
    checks++;
    assert (b_rd1 === exp_v) else begin
      errors++;
      $error("FAIL %s nobypass rd1 observed=%h expected=%h", tag, b_rd1, exp_v);
    end
  endtask

  initial begin
    // Reset held low while inputs toggle: everything must read zero.
    for (int i = 0; i < 4; i++) begin
      @(negedge Clock);
      IF_Valid       = 1'($urandom());
      IF_Instruction = $urandom();
      IF_PCPlus4     = $urandom();
      Flush          = 1'($urandom());
      WB_RegWrite    = 1'($urandom());
      WB_WriteReg    = 5'($urandom());
      WB_WriteData   = $urandom();
      #1;
      checks++;
      assert (obs === '0 && ID_Stall === 1'b0) else begin
        errors++;
        $error("FAIL reset_%0d observed=%h stall=%b expected=0", i, obs, ID_Stall);
      end
      checks++;
      assert (b_obs === '0 && b_stall === 1'b0) else begin
        errors++;
        $error("FAIL reset_nobyp_%0d observed=%h stall=%b expected=0", i, b_obs, b_stall);
      end
    end
    @(negedge Clock);
    Reset = 1'b1;

    step("idle", 1'b0, 32'h0, pc, 1'b0, 1'b0, 5'd0, 32'h0, 1'b0, BUB);

    wb("wb_r8", 5'd8, 32'd5);
    wb("wb_r9", 5'd9, 32'd7);
    wb("wb_r10", 5'd10, 32'd3);
    wb("wb_r12", 5'd12, 32'h40);
    wb("wb_r17", 5'd17, 32'h11);

    // ALU and immediate forms.
    iss("add", 32'h01098020, 1'b0, mk(32'h01098020, pc, C_ALU, 3'd0, 32'd5, 32'd7, 32'hFFFF8020, 5'd16));
    iss("addi", 32'h2151001A, 1'b0, mk(32'h2151001A, pc, C_ALUI, 3'd0, 32'd3, 32'h11, 32'd26, 5'd17));
    iss("andi_zext", 32'h314B8000, 1'b0, mk(32'h314B8000, pc, C_ALUI, 3'd2, 32'd3, 32'd0, 32'h0000_8000, 5'd11));
    iss("addi_neg", 32'h2151FFFF, 1'b0, mk(32'h2151FFFF, pc, C_ALUI, 3'd0, 32'd3, 32'h11, 32'hFFFF_FFFF, 5'd17));
    iss("ori", 32'h352D00F0, 1'b0, mk(32'h352D00F0, pc, C_ALUI, 3'd3, 32'd7, 32'd0, 32'h0000_00F0, 5'd13));

    // Load-use on rs, with a WB write to the load destination during the stall.
    iss("lw", 32'h8D940000, 1'b0, mk(32'h8D940000, pc, C_LW, 3'd0, 32'h40, 32'd0, 32'd0, 5'd20));
    step("sub_stall", 1'b1, 32'h02919022, pc, 1'b0, 1'b1, 5'd20, 32'h99, 1'b1, BUB);
    iss("sub", 32'h02919022, 1'b0, mk(32'h02919022, pc, C_ALU, 3'd1, 32'h99, 32'h11, 32'hFFFF9022, 5'd18));

    // rt only as destination: no stall.
    iss("lw2", 32'h8D940000, 1'b0, mk(32'h8D940000, pc, C_LW, 3'd0, 32'h40, 32'h99, 32'd0, 5'd20));
    iss("addi_rt_dst", 32'h21540001, 1'b0, mk(32'h21540001, pc, C_ALUI, 3'd0, 32'd3, 32'h99, 32'd1, 5'd20));

    // sw reads rt: stall.
    iss("lw3", 32'h8D940000, 1'b0, mk(32'h8D940000, pc, C_LW, 3'd0, 32'h40, 32'h99, 32'd0, 5'd20));
    step("sw_stall", 1'b1, 32'hAD540004, pc, 1'b0, 1'b0, 5'd0, 32'h0, 1'b1, BUB);
    iss("sw", 32'hAD540004, 1'b0, mk(32'hAD540004, pc, C_SW, 3'd0, 32'd3, 32'h99, 32'd4, 5'd20));

    // Load into r0 never stalls.
    iss("lw_r0", 32'h8D800000, 1'b0, mk(32'h8D800000, pc, C_LW, 3'd0, 32'h40, 32'd0, 32'd0, 5'd0));
    iss("add_rs0", 32'h00098020, 1'b0, mk(32'h00098020, pc, C_ALU, 3'd0, 32'd0, 32'd7, 32'hFFFF8020, 5'd16));

    // beq reads rt: stall; invalid ID never stalls.
    iss("lw4", 32'h8D940000, 1'b0, mk(32'h8D940000, pc, C_LW, 3'd0, 32'h40, 32'h99, 32'd0, 5'd20));
    step("beq_stall", 1'b1, 32'h11540003, pc, 1'b0, 1'b0, 5'd0, 32'h0, 1'b1, BUB);
    iss("beq_rt", 32'h11540003, 1'b0, mk(32'h11540003, pc, C_BEQ, 3'd1, 32'd3, 32'h99, 32'd3, 5'd20));
    iss("lw5", 32'h8D940000, 1'b0, mk(32'h8D940000, pc, C_LW, 3'd0, 32'h40, 32'h99, 32'd0, 5'd20));
    step("invalid_nostall", 1'b0, 32'h02919022, pc, 1'b0, 1'b0, 5'd0, 32'h0, 1'b0, BUB);

    // Same-cycle WB bypass: new value with bypass, old value (0) without.
    step("bypass", 1'b1, 32'h02089020, pc, 1'b0, 1'b1, 5'd16, 32'h1234, 1'b0,
         mk(32'h02089020, pc, C_ALU, 3'd0, 32'h1234, 32'd5, 32'hFFFF9020, 5'd18));
    chk_b_rd1("bypass_off", 32'h0);
    pc = pc + 32'd4;
    iss("reread_r16", 32'h02089020, 1'b0, mk(32'h02089020, pc, C_ALU, 3'd0, 32'h1234, 32'd5, 32'hFFFF9020, 5'd18));
    chk_b_rd1("reread_off", 32'h1234);

    // WB write to r0 during an r0 read, then r0 again.
    step("wb_r0", 1'b1, 32'h00000820, pc, 1'b0, 1'b1, 5'd0, 32'hDEAD, 1'b0,
         mk(32'h00000820, pc, C_ALU, 3'd0, 32'd0, 32'd0, 32'h0000_0820, 5'd1));
    chk_b_rd1("wb_r0_off", 32'h0);
    pc = pc + 32'd4;
    iss("r0_after", 32'h00000820, 1'b0, mk(32'h00000820, pc, C_ALU, 3'd0, 32'd0, 32'd0, 32'h0000_0820, 5'd1));

    // Flush during a load-use hazard: stall suppressed, bubble loaded.
    iss("lw6", 32'h8D940000, 1'b0, mk(32'h8D940000, pc, C_LW, 3'd0, 32'h40, 32'h99, 32'd0, 5'd20));
    step("flush_haz", 1'b1, 32'h02919022, pc, 1'b1, 1'b0, 5'd0, 32'h0, 1'b0, BUB);
    iss("mul", 32'h72119802, 1'b0, mk(32'h72119802, pc, C_ALU, 3'd5, 32'h1234, 32'h11, 32'hFFFF9802, 5'd19));
    iss("illegal_op", 32'hFC000000, 1'b0, mk(32'hFC000000, pc, C_ILL, 3'd0, 32'd0, 32'd0, 32'd0, 5'd0));
    iss("illegal_fn", 32'h00000000, 1'b0, mk(32'h00000000, pc, C_ILL, 3'd0, 32'd0, 32'd0, 32'd0, 5'd0));

    // Branch target wraps modulo 2^32.
    pc = 32'hFFFF_FFFC;
    iss("beq_wrap", 32'h11490003, 1'b0, mk(32'h11490003, pc, C_BEQ, 3'd1, 32'd3, 32'd7, 32'd3, 5'd9));

    step("not_valid", 1'b0, 32'h01098020, pc, 1'b0, 1'b0, 5'd0, 32'h0, 1'b0, BUB);
    step("flush_plain", 1'b1, 32'h01098020, pc, 1'b1, 1'b0, 5'd0, 32'h0, 1'b0, BUB);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
